// File: rtl/uart_tx_frame_feeder_if.sv
// Word-in / byte-out bundle between the upstream producer, the frame feeder
// and the 8N1 transmitter.
interface uart_tx_frame_feeder_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        tx_data;
  logic              tx_enable;
  logic              tx_busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              frame_done;

  // Environment side: word producer plus transmitter busy flag.
  modport master (
    output in_data, in_last, in_valid, tx_busy,
    input  in_ready, tx_data, tx_enable, fifo_count, frame_done
  );

  // Feeder side.
  modport slave (
    input  in_data, in_last, in_valid, tx_busy,
    output in_ready, tx_data, tx_enable, fifo_count, frame_done
  );
endinterface

// File: rtl/uart_tx_frame_feeder.sv
// Frame feeder for the 8N1 UART transmitter: buffers result words, sends
// sync byte, little-endian payload bytes and an 8-bit payload checksum.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no frame open; start one once a word is buffered and tx idle
// ST_LOAD    | frame open; pop the next word (waits here if FIFO empty)
// ST_ISSUE   | tx_enable high for this single cycle, tx_data valid
// ST_WAIT_HI | waiting for the transmitter to raise tx_busy
// ST_WAIT_LO | waiting for tx_busy to fall; then decide the next byte
//
// kind_q remembers which byte is in flight (sync, payload, checksum) so
// one issue/wait sequence serves all three.
module uart_tx_frame_feeder #(
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input logic clk_i,
  input logic rst_i,
  uart_tx_frame_feeder_if.slave io
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT_HI, ST_WAIT_LO} state_t;
  typedef enum logic [1:0] {K_SYNC, K_DATA, K_CSUM} kind_t;

  state_t state_q, state_d;
  kind_t  kind_q, kind_d;

  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              frame_done_q, frame_done_d;
  logic              push, pop, empty, ready;
  logic [DATA_W:0]   rd_entry;
  logic [7:0]        next_byte;

  // No full-bypass: readiness comes from the registered count alone.
  assign ready     = (count_q != CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = io.in_valid && ready;
  assign rd_entry  = mem_q[rd_ptr_q];
  assign idx_inc   = idx_q + IDX_W'(1);
  assign next_byte = 8'(word_q >> (8 * idx_inc));

  assign io.in_ready   = ready;
  assign io.tx_data    = tx_data_q;
  assign io.tx_enable  = (state_q == ST_ISSUE);
  assign io.fifo_count = count_q;
  assign io.frame_done = frame_done_q;

  // FIFO storage; pointers alone define validity so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {io.in_last, io.in_data};
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Next-state, byte selection and checksum accumulation.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    word_d       = word_q;
    last_d       = last_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Waiting for tx_busy low keeps a transmitter still finishing an
        // interrupted byte from being re-triggered after reset.
        if (!empty && !io.tx_busy) begin
          csum_d    = '0;
          tx_data_d = SYNC_BYTE;
          kind_d    = K_SYNC;
          state_d   = ST_ISSUE;
        end
      end
      ST_LOAD: begin
        if (!empty) begin
          pop       = 1'b1;
          word_d    = rd_entry[DATA_W-1:0];
          last_d    = rd_entry[DATA_W];
          idx_d     = '0;
          tx_data_d = rd_entry[7:0];
          csum_d    = csum_q + rd_entry[7:0];
          kind_d    = K_DATA;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (io.tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!io.tx_busy) begin
          case (kind_q)
            K_SYNC: state_d = ST_LOAD;
            K_DATA: begin
              if (idx_q != IDX_W'(NB - 1)) begin
                idx_d     = idx_inc;
                tx_data_d = next_byte;
                csum_d    = csum_q + next_byte;
                state_d   = ST_ISSUE;
              end else if (last_q) begin
                tx_data_d = csum_q;
                kind_d    = K_CSUM;
                state_d   = ST_ISSUE;
              end else begin
                state_d = ST_LOAD;
              end
            end
            default: begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, FIFO pointers and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      kind_q       <= K_SYNC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      csum_q       <= '0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      wr_ptr_q     <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q     <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q      <= count_d;
      word_q       <= word_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_feeder.sv
// Bench for uart_tx_frame_feeder: transmitter busy model, byte-stream
// reference built from the framing rules, protocol monitor.
module tb_uart_tx_frame_feeder;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_frame_feeder_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_tx_frame_feeder #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy rises rise_dly cycles after an enable and
  // stays high for high_len cycles. stall forces busy high.
  logic model_busy = 1'b0;
  logic stall = 1'b0;
  int   rise_dly = 3;
  int   high_len = 20;
  assign bus.tx_busy = model_busy | stall;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_enable === 1'b1) begin
        repeat (rise_dly) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (high_len) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Reference byte stream: sync, little-endian payload, payload sum mod 256.
  logic [7:0] exp_q[$];
  logic       frame_open = 1'b0;
  logic [7:0] ref_sum = 8'h00;

  task automatic model_word(input logic [DATA_W-1:0] d, input logic last);
    logic [7:0] b;
    if (!frame_open) begin
      exp_q.push_back(8'hA5);
      frame_open = 1'b1;
      ref_sum = 8'h00;
    end
    for (int k = 0; k < DATA_W / 8; k++) begin
      b = d[8*k +: 8];
      exp_q.push_back(b);
      ref_sum = ref_sum + b;
    end
    if (last) begin
      exp_q.push_back(ref_sum);
      frame_open = 1'b0;
    end
  endtask

  // Monitor: every issued byte is compared against the reference stream,
  // plus enable/hold protocol checks.
  int         en_cnt = 0;
  int         fd_cnt = 0;
  logic       pend = 1'b0;
  logic       prev_en = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_fd = 1'b0;
  logic [7:0] held = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (bus.tx_enable) begin
          check("en_while_busy", bus.tx_busy, 1'b0);
          check("en_width", prev_en, 1'b0);
          check("en_before_done", pend, 1'b0);
          pend = 1'b1;
          held = bus.tx_data;
          en_cnt++;
          if (exp_q.size() == 0) check("unexpected_byte_qsize", exp_q.size(), 1);
          else check("byte", bus.tx_data, exp_q.pop_front());
        end
        if (pend && prev_busy && !bus.tx_busy) begin
          check("tx_data_hold", bus.tx_data, held);
          pend = 1'b0;
        end
        if (bus.frame_done) begin
          check("frame_done_width", prev_fd, 1'b0);
          fd_cnt++;
        end
      end
      prev_en   = bus.tx_enable;
      prev_busy = bus.tx_busy;
      prev_fd   = bus.frame_done;
    end
  end

  // Drive one word from a negedge; returns at the negedge after acceptance.
  task automatic push_word(input logic [DATA_W-1:0] d, input logic last);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      check("push_accepted", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      return;
    end
    model_word(d, last);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_count", fd_cnt, target);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, f0, e1, n;
    logic [DATA_W-1:0] w [20];
    logic [DATA_W-1:0] w0;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_enable", bus.tx_enable, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_frame_done", bus.frame_done, 1'b0);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single word, latency to sync enable
    e0 = en_cnt; f0 = fd_cnt;
    push_word(16'h1234, 1'b1);
    check("t1_count_c1", bus.fifo_count, 1);
    check("t1_enable_c1", bus.tx_enable, 1'b0);
    @(negedge clk);
    check("t1_enable_c2", bus.tx_enable, 1'b1);
    wait_fd(f0 + 1, 1000);
    repeat (30) @(negedge clk);
    check("t1_frames", fd_cnt - f0, 1);
    check("t1_enables", en_cnt - e0, 4);
    check("t1_left", exp_q.size(), 0);

    // 2: three-word frame, checksum wrap
    e0 = en_cnt; f0 = fd_cnt;
    push_word(16'hFFFF, 1'b0);
    push_word(16'h0001, 1'b0);
    push_word(16'h8000, 1'b1);
    wait_fd(f0 + 1, 2000);
    check("t2_enables", en_cnt - e0, 8);
    check("t2_left", exp_q.size(), 0);

    // 3: FIFO fills while the transmitter is stalled busy
    e0 = en_cnt; f0 = fd_cnt;
    for (int i = 0; i < 20; i++) w[i] = DATA_W'($urandom);
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push_word(w[i], 1'b0);
    check("t3_in_ready_full", bus.in_ready, 1'b0);
    check("t3_count_full", bus.fifo_count, 16);
    bus.in_data  = w[16];
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_count_held", bus.fifo_count, 16);
    check("t3_no_enable", en_cnt - e0, 0);
    stall = 1'b0;
    for (int i = 16; i < 20; i++) push_word(w[i], (i == 19));
    wait_fd(f0 + 1, 5000);
    check("t3_enables", en_cnt - e0, 42);
    check("t3_left", exp_q.size(), 0);

    // 4: slow busy rise
    rise_dly = 10; high_len = 20;
    e0 = en_cnt; f0 = fd_cnt;
    push_word(DATA_W'($urandom), 1'b0);
    push_word(DATA_W'($urandom), 1'b1);
    wait_fd(f0 + 1, 2000);
    check("t4_enables", en_cnt - e0, 6);
    check("t4_left", exp_q.size(), 0);

    // 5: back-to-back one-word frames
    rise_dly = 3; high_len = 20;
    e0 = en_cnt; f0 = fd_cnt;
    push_word(16'hAAAA, 1'b1);
    push_word(16'h5555, 1'b1);
    wait_fd(f0 + 2, 2000);
    check("t5_enables", en_cnt - e0, 8);
    check("t5_left", exp_q.size(), 0);

    // 6: reset during the second byte while busy is high
    e0 = en_cnt; f0 = fd_cnt;
    w0 = DATA_W'($urandom);
    push_word(w0, 1'b0);
    push_word(DATA_W'($urandom), 1'b1);
    n = 0;
    while (en_cnt < e0 + 2 && n < 500) begin @(negedge clk); n++; end
    check("t6_second_byte_seen", en_cnt - e0, 2);
    n = 0;
    while (!bus.tx_busy && n < 50) begin @(negedge clk); n++; end
    check("t6_busy_before_rst", bus.tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_tx_enable", bus.tx_enable, 1'b0);
    check("t6_rst_fifo_count", bus.fifo_count, 0);
    rst = 1'b0;
    exp_q.delete();
    frame_open = 1'b0;
    e1 = en_cnt;
    push_word(16'h0102, 1'b1);
    n = 0;
    while (bus.tx_busy && n < 100) begin @(negedge clk); n++; end
    check("t6_no_enable_while_busy", en_cnt - e1, 0);
    wait_fd(f0 + 1, 2000);
    check("t6_enables", en_cnt - e1, 4);
    check("t6_left", exp_q.size(), 0);

    // 7: randomized frames and transmitter timing
    for (int f = 0; f < 8; f++) begin
      int nw;
      rise_dly = $urandom_range(1, 5);
      high_len = $urandom_range(1, 12);
      nw = $urandom_range(1, 5);
      e0 = en_cnt; f0 = fd_cnt;
      for (int i = 0; i < nw; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_word(DATA_W'($urandom), (i == nw - 1));
      end
      wait_fd(f0 + 1, 3000);
      check("t7_enables", en_cnt - e0, 2 + 2 * nw);
      check("t7_left", exp_q.size(), 0);
    end

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame_feeder.md
Name: uart_tx_frame_feeder

Overview:
- Sits directly upstream of the 8N1 UART transmitter and feeds it bytes.
- Buffers FFT result words in a small FIFO and splits each word into little-endian bytes.
- Wraps each frame with a sync header byte and a trailing 8-bit checksum.
- Drives the transmitter's enable/busy handshake so no byte is dropped or sent twice.

Parameters:
DATA_W, 16, input word width; must be a multiple of 8, range 8..32
FIFO_DEPTH, 16, word entries in the input FIFO; power of two, at least 2
SYNC_BYTE, 8'hA5, header byte sent before the first word of every frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_data  in  DATA_W  result word to transmit
in_last  in  1  marks the final word of a frame
in_valid  in  1  in_data/in_last valid
in_ready  out  1  FIFO can accept a word; equals !full
tx_data  out  8  byte presented to the transmitter
tx_enable  out  1  one-cycle request to the transmitter
tx_busy  in  1  transmitter busy flag
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered
frame_done  out  1  one-cycle pulse after the checksum byte completes

Behaviour:
- Reset (while rst sampled high at a clk edge):
  - tx_enable=0, tx_data=0, frame_done=0.
  - FIFO emptied: fifo_count=0, in_ready=1.
  - Checksum cleared; FSM goes to IDLE.
- Push: occurs when in_valid && in_ready. Stores {in_last, in_data}.
- Pop: occurs only in LOAD state.
- Simultaneous push and pop: count is unchanged.
- in_ready derives from the registered count only; there is no full-bypass, so a push is refused while full even if a pop happens in the same cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Byte issue handshake, used for every byte:
  - ISSUE: drive tx_data, pulse tx_enable for exactly 1 cycle, go to WAIT_HI.
  - WAIT_HI: wait until tx_busy==1, then go to WAIT_LO.
  - WAIT_LO: wait until tx_busy==0, then the byte is complete.
  - tx_data stays stable from ISSUE until the byte completes.
  - tx_enable is never asserted while tx_busy==1.
- FSM states:
  - IDLE: when FIFO non-empty and tx_busy==0, clear csum and issue SYNC_BYTE. After it completes, go to LOAD.
  - LOAD: if FIFO empty, stay in LOAD (frame still open). Otherwise pop into word register, latch its last flag, set byte_idx=0, go to BYTE.
  - BYTE: issue word[8*byte_idx +: 8]; csum <= csum + byte (mod 256) at ISSUE. After completion:
    - if byte_idx < DATA_W/8-1: increment byte_idx and stay in BYTE;
    - else if last flag set: go to CSUM;
    - else: go to LOAD.
  - CSUM: issue the csum byte. After it completes, pulse frame_done for 1 cycle and go to IDLE.
- Checksum arithmetic: 8-bit wraparound sum of payload bytes only; the sync byte is excluded.
- Latency: with tx_busy idle and the first word pushed at cycle 0, the sync byte's tx_enable pulses at cycle 2 (cycle 1 registers the FIFO write).
- Zero-length frames cannot occur; every frame holds at least one word.
- The FIFO may fill during a frame. The upstream stalls via in_ready; no data is lost.
- Reset mid-byte: the feeder returns to IDLE. Since IDLE requires tx_busy==0 before issuing, a transmitter still finishing a byte is never re-triggered. A partial frame is discarded; no checksum is sent for it.

Test Plan:
1. Single word: push 16'h1234 with last=1, with a transmitter model (busy rises 3 cycles after enable, stays high 20 cycles) -> bytes A5, 34, 12, 46; frame_done pulses once after the fourth byte; exactly 4 tx_enable pulses.
2. Three-word frame: push 16'hFFFF, 16'h0001, 16'h8000 (last on the third) -> bytes A5, FF, FF, 01, 00, 00, 80, 7F; checksum wraps correctly (0x27F mod 256 = 7F).
3. FIFO full: push 20 words back-to-back with the transmitter stalled busy -> in_ready drops after 16 accepted words; fifo_count=16; remaining words are held upstream; all 20 words later appear in order.
4. Handshake hold: a model with busy delayed 10 cycles -> tx_enable is a single 1-cycle pulse; tx_data is constant until busy falls; no second enable before busy has gone high then low.
5. Back-to-back frames: two 1-word frames (16'hAAAA last, 16'h5555 last) -> A5, AA, AA, 54, then A5, 55, 55, AA; frame_done pulses twice.
6. Reset mid-frame: assert rst during the second byte while busy=1 -> tx_enable=0, fifo_count=0 next cycle; after rst, push 16'h0102 last while busy is still high -> the sync byte is not issued until busy falls; then A5, 02, 01, 03.
